uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 119 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte requesters.
// One byte per grant; waits for TX done (or timeout), then one gap cycle before re-arbitrating.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int TIMEOUT_CLKS = 4774
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic [NUM_REQ-1:0]   i_Req,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic                 o_TX_DV,
  output logic [7:0]           o_TX_Byte,
  input  logic                 i_TX_Active,
  input  logic                 i_TX_Done,
  output logic                 o_Busy,
  output logic [2:0]           o_Owner,
  output logic                 o_Error
);
  localparam int              IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IW-1:0]   LAST_RST = IW'(NUM_REQ - 1);
  localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;

  state_t                    state_q, state_d;
  logic [15:0]               timer_q, timer_d;
  logic                      flag_q, flag_d;
  logic [IW-1:0]             last_q, last_d;
  logic [7:0]                byte_d;
  logic [2:0]                owner_d;
  logic [NUM_REQ-1:0]        grant_d;
  logic [NUM_REQ-1:0][7:0]   req_byte;
  logic                      win_vld;
  logic [IW-1:0]             win_idx, cand;

  assign req_byte = i_Req_Byte;

  // Search starts one past the last owner and wraps, so every requester gets a turn.
  always_comb begin
    win_vld = 1'b0;
    win_idx = last_q;
    cand    = last_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(last_q) + i) % NUM_REQ);
      if (!win_vld && i_Req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    flag_d  = flag_q;
    last_d  = last_q;
    byte_d  = o_TX_Byte;
    owner_d = o_Owner;
    grant_d = '0;
    unique case (state_q)
      IDLE: begin
        if (win_vld && !i_TX_Active) begin
          state_d          = LAUNCH;
          last_d           = win_idx;
          owner_d          = 3'(win_idx);
          byte_d           = req_byte[win_idx];
          grant_d[win_idx] = 1'b1;
        end
      end
      // A done seen while launching belongs to an earlier frame and is dropped.
      LAUNCH: begin
        state_d = WAIT_DONE;
        timer_d = '0;
      end
      WAIT_DONE: begin
        if (i_TX_Done) begin
          state_d = GAP;
        end else if (timer_q == TMO_LAST) begin
          state_d = GAP;
          flag_d  = 1'b1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      GAP: begin
        state_d = IDLE;
        flag_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      flag_q    <= 1'b0;
      last_q    <= LAST_RST;
      o_Grant   <= '0;
      o_TX_DV   <= 1'b0;
      o_TX_Byte <= '0;
      o_Busy    <= 1'b0;
      o_Owner   <= '0;
      o_Error   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      flag_q    <= flag_d;
      last_q    <= last_d;
      o_Grant   <= grant_d;
      o_TX_DV   <= (state_d == LAUNCH);
      o_TX_Byte <= byte_d;
      o_Busy    <= (state_d != IDLE);
      o_Owner   <= owner_d;
      o_Error   <= (state_d == GAP) && flag_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a transaction-timing model.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int T     = 100;
  localparam int NEVER = 100000;

  logic           i_Clk = 1'b0, i_Rst_L = 1'b1;
  logic [N-1:0]   i_Req = '0;
  logic [8*N-1:0] i_Req_Byte = '0;
  logic           i_TX_Active = 1'b0, i_TX_Done = 1'b0;
  logic [N-1:0]   o_Grant;
  logic           o_TX_DV, o_Busy, o_Error;
  logic [7:0]     o_TX_Byte;
  logic [2:0]     o_Owner;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CLKS(T)) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Req(i_Req), .i_Req_Byte(i_Req_Byte),
    .o_Grant(o_Grant), .o_TX_DV(o_TX_DV), .o_TX_Byte(o_TX_Byte),
    .i_TX_Active(i_TX_Active), .i_TX_Done(i_TX_Done), .o_Busy(o_Busy),
    .o_Owner(o_Owner), .o_Error(o_Error)
  );

  always #5 i_Clk = ~i_Clk;

  int vec_cnt = 0, miscmp = 0;
  int cyc = 0, launch_c, gap_c, done_c, last, owner, fix_d = 0, err_seen = 0;
  bit timed_out, noise = 1'b0;
  logic [7:0]   cap;
  logic [7:0]   dv_log[$];
  logic [N-1:0] gnt_log[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d t=%0t", tag, got, exp, cyc, $time);
    end
  endtask

  task automatic model_reset();
    last = N - 1; owner = 0; cap = 8'h00;
    launch_c = -10; gap_c = -10; done_c = -10; timed_out = 1'b0;
  endtask

  task automatic clear_logs();
    dv_log.delete(); gnt_log.delete(); err_seen = 0;
  endtask

  function automatic int pick_delay();
    if (fix_d != 0) return fix_d;
    if ($urandom_range(0, 4) == 0) return int'($urandom_range(T - 2, T + 3));
    return int'($urandom_range(1, 12));
  endfunction

  function automatic logic [8*N-1:0] rnd_bytes();
    logic [8*N-1:0] b;
    for (int k = 0; k < N; k++) b[8*k +: 8] = 8'($urandom);
    return b;
  endfunction

  // One clock: check this cycle against the model, drive next inputs, predict the edge.
  task automatic step(input logic [N-1:0] req, input logic act, input logic [8*N-1:0] bytes);
    int d;
    bit found;
    @(negedge i_Clk);
    cyc++;
    if (o_TX_DV) begin dv_log.push_back(o_TX_Byte); gnt_log.push_back(o_Grant); end
    if (o_Error) err_seen++;
    chk("grant", 32'(o_Grant), (cyc == launch_c) ? (32'd1 << owner) : 32'd0);
    chk("tx_dv", 32'(o_TX_DV), 32'(cyc == launch_c));
    chk("busy",  32'(o_Busy),  32'(cyc >= launch_c && cyc <= gap_c));
    chk("error", 32'(o_Error), 32'(cyc == gap_c && timed_out));
    chk("owner", 32'(o_Owner), 32'(owner));
    chk("byte",  32'(o_TX_Byte), 32'(cap));
    i_Req = req; i_TX_Active = act; i_Req_Byte = bytes;
    i_TX_Done = (cyc == done_c) ||
                (noise && !(cyc > launch_c && cyc < gap_c) && $urandom_range(0, 7) == 0);
    if (cyc > gap_c && (|req) && !act) begin
      found = 1'b0;
      for (int i = 1; i <= N; i++) begin
        if (!found && req[(last + i) % N]) begin owner = (last + i) % N; found = 1'b1; end
      end
      last      = owner;
      cap       = bytes[8*owner +: 8];
      launch_c  = cyc + 1;
      d         = pick_delay();
      timed_out = (d > T);
      done_c    = timed_out ? -10 : launch_c + d;
      gap_c     = launch_c + (timed_out ? T : d) + 1;
    end
  endtask

  task automatic run(input int n, input logic [N-1:0] req, input logic act,
                     input bit rb, input logic [8*N-1:0] bytes);
    for (int k = 0; k < n; k++) step(req, act, rb ? rnd_bytes() : bytes);
  endtask

  task automatic wait_launches(input int cnt, input logic [N-1:0] req,
                               input bit rb, input logic [8*N-1:0] bytes, input int bound);
    int g = 0;
    while (dv_log.size() < cnt && g < bound) begin
      step(req, 1'b0, rb ? rnd_bytes() : bytes);
      g++;
    end
    chk("launch_cnt", 32'(dv_log.size()), 32'(cnt));
  endtask

  task automatic apply_reset();
    @(posedge i_Clk); #2;
    i_Rst_L = 1'b0; i_Req = '0; i_TX_Done = 1'b0; i_TX_Active = 1'b0;
    #1;
    chk("rst_grant", 32'(o_Grant), 32'd0);
    chk("rst_dv",    32'(o_TX_DV), 32'd0);
    chk("rst_byte",  32'(o_TX_Byte), 32'd0);
    chk("rst_busy",  32'(o_Busy), 32'd0);
    chk("rst_owner", 32'(o_Owner), 32'd0);
    chk("rst_error", 32'(o_Error), 32'd0);
    model_reset();
    repeat (2) @(negedge i_Clk);
    i_Rst_L = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    model_reset();
    #2;
    apply_reset();

    // Single request from ch2, done well before timeout
    fix_d = 60; clear_logs();
    step(4'b0100, 1'b0, {8'h5a, 8'h37, 8'ha5, 8'h01});
    run(70, '0, 1'b0, 1'b1, '0);
    chk("r32_cnt", 32'(dv_log.size()), 32'd1);
    chk("r32_byte", 32'(dv_log[0]), 32'h37);
    chk("r32_grant", 32'(gnt_log[0]), 32'b0100);
    chk("r32_err", 32'(err_seen), 32'd0);

    // All four held: rotation 0,1,2,3,0
    apply_reset(); fix_d = 20; clear_logs();
    wait_launches(5, 4'b1111, 1'b0, {8'h13, 8'h12, 8'h11, 8'h10}, 300);
    run(30, '0, 1'b0, 1'b1, '0);
    for (int k = 0; k < 5; k++) chk("r33_order", 32'(dv_log[k]), 32'(8'h10 + k % 4));

    // ch0/ch3 alternate; TX busy holds off arbitration
    apply_reset(); fix_d = 5; clear_logs();
    wait_launches(4, 4'b1001, 1'b1, '0, 200);
    run(15, '0, 1'b0, 1'b1, '0);
    for (int k = 0; k < 4; k++) chk("r34_alt", 32'(gnt_log[k]), (k % 2 == 0) ? 32'b0001 : 32'b1000);
    clear_logs();
    run(20, 4'b0010, 1'b1, 1'b1, '0);
    chk("r34_hold", 32'(dv_log.size()), 32'd0);
    step(4'b0010, 1'b0, rnd_bytes());
    run(15, '0, 1'b0, 1'b1, '0);
    chk("r34_rel", 32'(gnt_log[0]), 32'b0010);

    // Timeout then next pending requester
    apply_reset(); fix_d = NEVER; clear_logs();
    step(4'b0010, 1'b0, rnd_bytes());
    fix_d = 3;
    run(110, 4'b1000, 1'b0, 1'b1, '0);
    chk("r35_err", 32'(err_seen), 32'd1);
    chk("r35_next", 32'(gnt_log[1]), 32'b1000);

    // Done on the last allowed cycle wins over timeout
    apply_reset(); fix_d = T; clear_logs();
    step(4'b0001, 1'b0, rnd_bytes());
    run(110, '0, 1'b0, 1'b1, '0);
    chk("r36_err", 32'(err_seen), 32'd0);
    chk("r36_cnt", 32'(dv_log.size()), 32'd1);

    // Reset while ch2 owns the transmitter
    apply_reset(); fix_d = NEVER; clear_logs();
    step(4'b0100, 1'b0, rnd_bytes());
    run(10, '0, 1'b0, 1'b1, '0);
    apply_reset(); fix_d = 4; clear_logs();
    run(30, 4'b0011, 1'b0, 1'b1, '0);
    chk("r37_first", 32'(gnt_log[0]), 32'b0001);
    chk("r37_second", 32'(gnt_log[1]), 32'b0010);
    chk("r37_err", 32'(err_seen), 32'd0);

    // Random traffic with stale done pulses and one mid-run reset
    apply_reset(); fix_d = 0; noise = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] r;
      for (int b = 0; b < N; b++) r[b] = ($urandom_range(0, 9) < 4);
      if (k == 1500) apply_reset();
      step(r, ($urandom_range(0, 6) == 0), rnd_bytes());
    end
    noise = 1'b0;
    run(120, '0, 1'b0, 1'b1, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end
endmodule
